// File: rtl/datapath_ctrl.sv
// ============================================================================
// datapath_ctrl
// ----------------------------------------------------------------------------
// Control sequencer for the datapath. One 16-bit instruction is accepted per
// s/w handshake. The instruction is decoded and then driven out as a fixed,
// multi-cycle sequence of datapath strobes:
//   register reads into A and B, ALU/shift, C or status load, register write.
//
// Optional feature macro: DATAPATH_CTRL_ILLEGAL_FLAG_EN
//   When defined, the o_illegal output exists as a registered sticky flag.
//   It is set when an illegal encoding leaves S_DECODE, and it is cleared by
//   reset or by the next accepted instruction.
//   When undefined, the port is absent and illegal encodings return to
//   S_WAIT silently.
//
// Ports
//   i_clk          rising-edge clock
//   i_reset        asynchronous, active-high reset
//   i_s            start request, sampled only while o_w=1
//   i_instr        instruction, captured on the edge where s&w=1
//   o_w            ready/idle (1 only in S_WAIT)
//   o_readnum      register-file read address
//   o_writenum     register-file write address
//   o_write        register-file write enable
//   o_vsel         write-back select (1=datapath_in, 0=C)
//   o_loada        load A
//   o_loadb        load B
//   o_asel         force ALU A input to 0
//   o_bsel         alternate B source select (always 0)
//   o_shift        shifter operation applied to B
//   o_ALUop        00 add, 01 sub, 10 and, 11 not-B
//   o_loadc        load C
//   o_loads        load status (Z)
//   o_datapath_in  sign-extended imm8 taken from the instruction register
//   o_illegal      sticky illegal-encoding flag (macro-dependent)
// ============================================================================
module datapath_ctrl #(
    parameter int DW    = 16,
    parameter int RW    = 3,
    parameter int IMM_W = 8
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_s,
    input  logic [15:0]   i_instr,
    output logic          o_w,
    output logic [RW-1:0] o_readnum,
    output logic [RW-1:0] o_writenum,
    output logic          o_write,
    output logic          o_vsel,
    output logic          o_loada,
    output logic          o_loadb,
    output logic          o_asel,
    output logic          o_bsel,
    output logic [1:0]    o_shift,
    output logic [1:0]    o_ALUop,
    output logic          o_loadc,
    output logic          o_loads,
`ifdef DATAPATH_CTRL_ILLEGAL_FLAG_EN
    output logic [DW-1:0] o_datapath_in,
    output logic          o_illegal
`else
    output logic [DW-1:0] o_datapath_in
`endif
);

    typedef enum logic [2:0] {
        S_WAIT,
        S_DECODE,
        S_GETA,
        S_GETB,
        S_ALU,
        S_WRD,
        S_WIMM
    } state_t;

    state_t      r_state;
    state_t      w_nextState;
    logic [15:0] r_ir;

    logic [2:0]    w_opc;
    logic [1:0]    w_op;
    logic [RW-1:0] w_rn;
    logic [RW-1:0] w_rd;
    logic [RW-1:0] w_rm;
    logic [1:0]    w_sh;
    logic          w_accept;
    logic          w_isMovImm;
    logic          w_isMovReg;
    logic          w_isAlu;
    logic          w_isCmp;
    logic          w_isMvn;
    logic          w_legal;

    // Register fields are taken from the instruction register.
    assign w_opc = r_ir[15:13];
    assign w_op  = r_ir[12:11];
    assign w_rn  = r_ir[10:8];
    assign w_rd  = r_ir[7:5];
    assign w_sh  = r_ir[4:3];
    assign w_rm  = r_ir[2:0];

    assign w_accept   = (r_state == S_WAIT) && i_s;
    assign w_isMovImm = (w_opc == 3'b110) && (w_op == 2'b10);
    assign w_isMovReg = (w_opc == 3'b110) && (w_op == 2'b00);
    assign w_isAlu    = (w_opc == 3'b101);
    assign w_isCmp    = w_isAlu && (w_op == 2'b01);
    assign w_isMvn    = w_isAlu && (w_op == 2'b11);
    assign w_legal    = w_isMovImm || w_isMovReg || w_isAlu;

    // The immediate is sign-extended from the held IR, so it reads 0 after reset.
    assign o_datapath_in = {{(DW-IMM_W){r_ir[IMM_W-1]}}, r_ir[IMM_W-1:0]};

    // The state register and the instruction register share the async reset.
    // The IR only loads on an accept, so instruction changes while busy are ignored.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_WAIT;
            r_ir    <= '0;
        end else begin
            r_state <= w_nextState;
            if (w_accept) begin
                r_ir <= i_instr;
            end
        end
    end

`ifdef DATAPATH_CTRL_ILLEGAL_FLAG_EN
    logic r_illegal;

    // The flag is sticky until the next accepted instruction.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_illegal <= 1'b0;
        end else if (w_accept) begin
            r_illegal <= 1'b0;
        end else if ((r_state == S_DECODE) && !w_legal) begin
            r_illegal <= 1'b1;
        end
    end

    assign o_illegal = r_illegal;
`endif

    // Next-state logic and strobe decode. The outputs depend only on the
    // registered state and the IR, so each strobe is glitch-free for a full cycle.
    always_comb begin
        w_nextState = r_state;
        o_w         = 1'b0;
        o_readnum   = '0;
        o_writenum  = '0;
        o_write     = 1'b0;
        o_vsel      = 1'b0;
        o_loada     = 1'b0;
        o_loadb     = 1'b0;
        o_asel      = 1'b0;
        o_bsel      = 1'b0;
        o_shift     = 2'b00;
        o_ALUop     = 2'b00;
        o_loadc     = 1'b0;
        o_loads     = 1'b0;

        case (r_state)
            S_WAIT: begin
                o_w = 1'b1;
                if (i_s) begin
                    w_nextState = S_DECODE;
                end
            end
            S_DECODE: begin
                if (w_isMovImm) begin
                    w_nextState = S_WIMM;
                end else if (w_isMovReg || w_isMvn) begin
                    w_nextState = S_GETB;
                end else if (w_isAlu) begin
                    w_nextState = S_GETA;
                end else begin
                    w_nextState = S_WAIT;
                end
            end
            S_GETA: begin
                o_readnum   = w_rn;
                o_loada     = 1'b1;
                w_nextState = S_GETB;
            end
            S_GETB: begin
                o_readnum   = w_rm;
                o_loadb     = 1'b1;
                w_nextState = S_ALU;
            end
            S_ALU: begin
                o_shift = w_sh;
                // A register-to-register move is an add with A forced to zero.
                if (w_isMovReg) begin
                    o_asel  = 1'b1;
                    o_ALUop = 2'b00;
                end else begin
                    o_ALUop = w_op;
                end
                // A compare only updates status and has no destination.
                if (w_isCmp) begin
                    o_loads     = 1'b1;
                    w_nextState = S_WAIT;
                end else begin
                    o_loadc     = 1'b1;
                    w_nextState = S_WRD;
                end
            end
            S_WRD: begin
                o_writenum  = w_rd;
                o_write     = 1'b1;
                w_nextState = S_WAIT;
            end
            S_WIMM: begin
                o_writenum  = w_rn;
                o_vsel      = 1'b1;
                o_write     = 1'b1;
                w_nextState = S_WAIT;
            end
            default: begin
                w_nextState = S_WAIT;
            end
        endcase
    end

endmodule

// File: tb/tb_datapath_ctrl.sv
// ============================================================================
// tb_datapath_ctrl
// ----------------------------------------------------------------------------
// Directed testbench for datapath_ctrl. It applies hand-written instructions
// and compares a packed snapshot of the control outputs, taken each cycle,
// against expected constants. If DATAPATH_CTRL_ILLEGAL_FLAG_EN is defined, it
// also checks the sticky illegal flag.
// ============================================================================
module tb_datapath_ctrl;

    logic        clk;
    logic        reset;
    logic        s;
    logic [15:0] instr;
    logic        w;
    logic [2:0]  readnum;
    logic [2:0]  writenum;
    logic        write;
    logic        vsel;
    logic        loada;
    logic        loadb;
    logic        asel;
    logic        bsel;
    logic [1:0]  shift;
    logic [1:0]  ALUop;
    logic        loadc;
    logic        loads;
    logic [15:0] datapath_in;
`ifdef DATAPATH_CTRL_ILLEGAL_FLAG_EN
    logic        illegal;
`endif

    int checkCount;
    int passCount;
    int writeCount;

    datapath_ctrl dut (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_s           (s),
        .i_instr       (instr),
        .o_w           (w),
        .o_readnum     (readnum),
        .o_writenum    (writenum),
        .o_write       (write),
        .o_vsel        (vsel),
        .o_loada       (loada),
        .o_loadb       (loadb),
        .o_asel        (asel),
        .o_bsel        (bsel),
        .o_shift       (shift),
        .o_ALUop       (ALUop),
        .o_loadc       (loadc),
        .o_loads       (loads),
`ifdef DATAPATH_CTRL_ILLEGAL_FLAG_EN
        .o_datapath_in (datapath_in),
        .o_illegal     (illegal)
`else
        .o_datapath_in (datapath_in)
`endif
    );

    // Free-running clock with a period of 10 time units.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Field order of the packed snapshot:
    // {w, write, vsel, loada, loadb, asel, bsel, loadc, loads, shift, ALUop, readnum, writenum}
    function automatic logic [31:0] mk(input logic pw, input logic pwrite, input logic pvsel,
                                       input logic pla, input logic plb, input logic pas,
                                       input logic pbs, input logic plc, input logic pls,
                                       input logic [1:0] psh, input logic [1:0] pop,
                                       input logic [2:0] prn, input logic [2:0] pwn);
        return {13'd0, pw, pwrite, pvsel, pla, plb, pas, pbs, plc, pls, psh, pop, prn, pwn};
    endfunction

    function automatic logic [31:0] snap();
        return {13'd0, w, write, vsel, loada, loadb, asel, bsel, loadc, loads,
                shift, ALUop, readnum, writenum};
    endfunction

    // Compares one observed value with its expected value and counts the result.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Advances one clock cycle and samples 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents an instruction with s=1 for exactly one edge, then drops s.
    task automatic applyStimulus(input logic [15:0] ins);
        instr = ins;
        s     = 1'b1;
        tick();
        s     = 1'b0;
    endtask

    localparam logic [31:0] IDLE = 32'h0004_0000;
    localparam logic [31:0] BUSY = 32'h0;

    initial begin
        checkCount = 0;
        passCount  = 0;
        writeCount = 0;
        s          = 1'b0;
        instr      = 16'h0000;
        reset      = 1'b1;
        tick();
        tick();
        checkOutput("reset outputs", snap(), IDLE);
        checkOutput("reset datapath_in", {16'd0, datapath_in}, 32'h0);
`ifdef DATAPATH_CTRL_ILLEGAL_FLAG_EN
        checkOutput("reset illegal", {31'd0, illegal}, 32'h0);
`endif
        reset = 1'b0;
        tick();
        checkOutput("idle after reset", snap(), IDLE);

        // MOV R0,#7
        applyStimulus(16'hD007);
        checkOutput("movi7 decode", snap(), BUSY);
        tick();
        checkOutput("movi7 wimm", snap(), mk(0,1,1,0,0,0,0,0,0,2'd0,2'd0,3'd0,3'd0));
        checkOutput("movi7 dp_in", {16'd0, datapath_in}, 32'h0007);
        tick();
        checkOutput("movi7 done", snap(), IDLE);

        // MOV R3,#-1
        applyStimulus(16'hD3FF);
        checkOutput("movim1 decode", snap(), BUSY);
        tick();
        checkOutput("movim1 wimm", snap(), mk(0,1,1,0,0,0,0,0,0,2'd0,2'd0,3'd0,3'd3));
        checkOutput("movim1 dp_in", {16'd0, datapath_in}, 32'hFFFF);
        tick();
        checkOutput("movim1 done", snap(), IDLE);
        tick();
        checkOutput("movim1 idle", snap(), IDLE);

        // ADD R2,R1,R0,LSL#1
        applyStimulus(16'hA148);
        checkOutput("add decode", snap(), BUSY);
        tick();
        checkOutput("add geta", snap(), mk(0,0,0,1,0,0,0,0,0,2'd0,2'd0,3'd1,3'd0));
        tick();
        checkOutput("add getb", snap(), mk(0,0,0,0,1,0,0,0,0,2'd0,2'd0,3'd0,3'd0));
        tick();
        checkOutput("add alu", snap(), mk(0,0,0,0,0,0,0,1,0,2'd1,2'd0,3'd0,3'd0));
        tick();
        checkOutput("add wrd", snap(), mk(0,1,0,0,0,0,0,0,0,2'd0,2'd0,3'd0,3'd2));
        tick();
        checkOutput("add done", snap(), IDLE);

        // CMP R1,R0. A mid-sequence s pulse and an instr change must be ignored.
        applyStimulus(16'hA900);
        checkOutput("cmp decode", snap(), BUSY);
        s     = 1'b1;
        instr = 16'hD007;
        tick();
        checkOutput("cmp geta", snap(), mk(0,0,0,1,0,0,0,0,0,2'd0,2'd0,3'd1,3'd0));
        s     = 1'b0;
        tick();
        checkOutput("cmp getb", snap(), mk(0,0,0,0,1,0,0,0,0,2'd0,2'd0,3'd0,3'd0));
        tick();
        checkOutput("cmp alu", snap(), mk(0,0,0,0,0,0,0,0,1,2'd0,2'd1,3'd0,3'd0));
        tick();
        checkOutput("cmp done", snap(), IDLE);
        tick();
        checkOutput("cmp s not queued", snap(), IDLE);

        // MVN R5,R2,LSR#1
        applyStimulus(16'hB8B2);
        checkOutput("mvn decode", snap(), BUSY);
        tick();
        checkOutput("mvn getb", snap(), mk(0,0,0,0,1,0,0,0,0,2'd0,2'd0,3'd2,3'd0));
        tick();
        checkOutput("mvn alu", snap(), mk(0,0,0,0,0,0,0,1,0,2'd2,2'd3,3'd0,3'd0));
        tick();
        checkOutput("mvn wrd", snap(), mk(0,1,0,0,0,0,0,0,0,2'd0,2'd0,3'd0,3'd5));
        tick();
        checkOutput("mvn done", snap(), IDLE);

        // MOV R7,R1
        applyStimulus(16'hC0E1);
        tick();
        checkOutput("movr getb", snap(), mk(0,0,0,0,1,0,0,0,0,2'd0,2'd0,3'd1,3'd0));
        tick();
        checkOutput("movr alu", snap(), mk(0,0,0,0,0,1,0,1,0,2'd0,2'd0,3'd0,3'd0));
        tick();
        checkOutput("movr wrd", snap(), mk(0,1,0,0,0,0,0,0,0,2'd0,2'd0,3'd0,3'd7));
        tick();
        checkOutput("movr done", snap(), IDLE);

        // AND R4,R3,R2
        applyStimulus(16'hB382);
        tick();
        checkOutput("and geta", snap(), mk(0,0,0,1,0,0,0,0,0,2'd0,2'd0,3'd3,3'd0));
        tick();
        tick();
        checkOutput("and alu", snap(), mk(0,0,0,0,0,0,0,1,0,2'd0,2'd2,3'd0,3'd0));
        tick();
        checkOutput("and wrd", snap(), mk(0,1,0,0,0,0,0,0,0,2'd0,2'd0,3'd0,3'd4));
        tick();
        checkOutput("and done", snap(), IDLE);

        // Reset asserted during S_GETB of ADD: the sequence aborts immediately.
        applyStimulus(16'hA148);
        tick();
        tick();
        checkOutput("abort in getb", snap(), mk(0,0,0,0,1,0,0,0,0,2'd0,2'd0,3'd0,3'd0));
        #2;
        reset = 1'b1;
        #1;
        checkOutput("abort async outputs", snap(), IDLE);
        checkOutput("abort dp_in", {16'd0, datapath_in}, 32'h0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (write) writeCount++;
        end
        checkOutput("abort no write", writeCount, 0);
        checkOutput("abort idle", snap(), IDLE);

        // An illegal encoding returns to S_WAIT after one edge without strobes.
        applyStimulus(16'h0000);
        checkOutput("illegal decode", snap(), BUSY);
        tick();
        checkOutput("illegal done", snap(), IDLE);
`ifdef DATAPATH_CTRL_ILLEGAL_FLAG_EN
        checkOutput("illegal flag set", {31'd0, illegal}, 32'h1);
        tick();
        checkOutput("illegal flag sticky", {31'd0, illegal}, 32'h1);
        applyStimulus(16'hD007);
        checkOutput("illegal flag cleared", {31'd0, illegal}, 32'h0);
        tick();
        tick();
`endif
        checkOutput("final idle", snap(), IDLE);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
